// File: rtl/bus_cycle_seq.sv
// Machine-cycle T-state sequencer for an 8085-compatible core.
// Drives ALE, strobes, status and the multiplexed AD bus from x1.
module bus_cycle_seq #(
    parameter int FETCH_T    = 4,
    parameter int WAIT_LIMIT = 0
) (
    input  logic        x1,
    input  logic        resetn_in,
    input  logic        req,
    input  logic [2:0]  cyc,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic        ack,
    output logic        done,
    output logic [7:0]  rdata,
    input  logic        ready,
    input  logic        hold,
    output logic        hlda,
    output logic        ale,
    output logic        rd_n,
    output logic        wr_n,
    output logic        inta_n,
    output logic        io_m,
    output logic        s1,
    output logic        s0,
    output logic [7:0]  a_hi,
    output logic        a_oe,
    output logic [7:0]  ad_out,
    output logic        ad_oe,
    input  logic [7:0]  ad_in,
    output logic [2:0]  t_state,
    output logic        wait_to
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_TW   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_HOLD = 3'd6
    } state_t;

    localparam logic [2:0] XLAST = 3'(FETCH_T - 4);
    localparam logic [7:0] WLIM  = 8'(WAIT_LIMIT);

    state_t      state, state_n;
    logic        ph;
    logic [2:0]  cyc_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rdata_q;
    logic        ack_q, done_q, wto_q;
    logic [7:0]  wcnt;
    logic [2:0]  xcnt;
    logic        acc, take, fin, lim_hit;
    logic        cyc_ok, is_wr, is_rd, in_cyc, win;
    logic [2:0]  stat;

    assign cyc_ok = (cyc <= 3'd5);
    assign is_wr  = (cyc_q == 3'd2) || (cyc_q == 3'd4);
    assign is_rd  = (cyc_q == 3'd0) || (cyc_q == 3'd1) || (cyc_q == 3'd3);

    // Transitions happen only at the end of a T-state (ph=1 half).
    always_comb begin
        state_n = state;
        acc     = 1'b0;
        take    = 1'b0;
        fin     = 1'b0;
        lim_hit = 1'b0;
        if (ph) begin
            unique case (state)
                S_T1: state_n = S_T2;
                S_T2: state_n = ready ? S_T3 : S_TW;
                S_TW: begin
                    if (WAIT_LIMIT > 0 && wcnt == WLIM) begin
                        state_n = S_T3;
                        lim_hit = 1'b1;
                    end else begin
                        state_n = ready ? S_T3 : S_TW;
                    end
                end
                S_T3: begin
                    if (cyc_q == 3'd0) begin
                        state_n = S_T4;
                    end else begin
                        fin = 1'b1;
                        acc = 1'b1;
                    end
                end
                S_T4: begin
                    if (xcnt == XLAST) begin
                        fin = 1'b1;
                        acc = 1'b1;
                    end
                end
                default: acc = 1'b1;
            endcase
            if (acc) begin
                if (hold) begin
                    state_n = S_HOLD;
                end else if (req && cyc_ok) begin
                    state_n = S_T1;
                    take    = 1'b1;
                end else begin
                    state_n = S_IDLE;
                end
            end
        end
    end

    always_ff @(posedge x1 or negedge resetn_in) begin
        if (!resetn_in) begin
            state   <= S_IDLE;
            ph      <= 1'b0;
            cyc_q   <= 3'd0;
            addr_q  <= 16'd0;
            wdata_q <= 8'd0;
            rdata_q <= 8'd0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            wto_q   <= 1'b0;
            wcnt    <= 8'd0;
            xcnt    <= 3'd0;
        end else begin
            ph     <= ~ph;
            state  <= state_n;
            ack_q  <= take;
            done_q <= fin;
            if (take) begin
                cyc_q   <= cyc;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (ph && state == S_T3 && !is_wr) rdata_q <= ad_in;
            if (ph && state_n == S_TW)
                wcnt <= (state == S_TW) ? wcnt + 8'd1 : 8'd1;
            if (ph && state == S_T3) xcnt <= 3'd0;
            else if (ph && state == S_T4) xcnt <= xcnt + 3'd1;
            if (lim_hit) wto_q <= 1'b1;
        end
    end

    assign in_cyc = (state == S_T1) || (state == S_T2) || (state == S_TW) ||
                    (state == S_T3) || (state == S_T4);
    assign win    = (state == S_T2) || (state == S_TW) || (state == S_T3);

    always_comb begin
        stat = 3'b000;
        if (in_cyc) begin
            unique case (cyc_q)
                3'd0:    stat = 3'b011;
                3'd1:    stat = 3'b010;
                3'd2:    stat = 3'b001;
                3'd3:    stat = 3'b110;
                3'd4:    stat = 3'b101;
                default: stat = 3'b111;
            endcase
        end
    end

    assign io_m    = stat[2];
    assign s1      = stat[1];
    assign s0      = stat[0];
    assign ack     = ack_q;
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign wait_to = wto_q;
    assign hlda    = (state == S_HOLD);
    assign ale     = (state == S_T1) && !ph;
    assign rd_n    = !(win && is_rd);
    assign wr_n    = !(win && is_wr);
    assign inta_n  = !(win && cyc_q == 3'd5);
    assign a_oe    = in_cyc;
    assign a_hi    = addr_q[15:8];
    assign ad_oe   = (state == S_T1) || (win && is_wr);
    assign ad_out  = (state == S_T1) ? addr_q[7:0] : wdata_q;
    assign t_state = state;

endmodule

// File: doc/bus_cycle_seq.md
Name: bus_cycle_seq

Overview:
- Machine-cycle timing sequencer for the 8085-compatible CPU.
- Sits directly downstream of the clock/reset generator and runs on the crystal clock x1.
- The core requests one machine cycle at a time: opcode fetch, memory read/write, I/O read/write or interrupt acknowledge. The sequencer steps through T-states and drives ALE, the strobes, the status lines and the multiplexed AD bus.
- Handles READY wait states and the HOLD/HLDA bus handover.

Parameters:
- FETCH_T, 4, T-states in an opcode-fetch cycle; legal values 4 or 6. Extra states T5/T6 behave like T4.
- WAIT_LIMIT, 0, maximum consecutive TW states; 0 means unlimited.

Ports:
- x1, in, 1, crystal clock; all logic on its rising edge.
- resetn_in, in, 1, asynchronous active-low reset.
- req, in, 1, core requests a machine cycle.
- cyc, in, 3, cycle type: 000 fetch, 001 mem rd, 010 mem wr, 011 io rd, 100 io wr, 101 int ack; 110/111 illegal.
- addr, in, 16, cycle address.
- wdata, in, 8, write data.
- ack, out, 1, one-x1 pulse: request accepted.
- done, out, 1, one-x1 pulse: cycle complete.
- rdata, out, 8, data captured in read, fetch and int-ack cycles.
- ready, in, 1, external READY.
- hold, in, 1, external HOLD.
- hlda, out, 1, hold acknowledge.
- ale, out, 1, address latch enable.
- rd_n, out, 1, read strobe.
- wr_n, out, 1, write strobe.
- inta_n, out, 1, interrupt acknowledge strobe.
- io_m, out, 1, status line IO/M.
- s1, out, 1, status line S1.
- s0, out, 1, status line S0.
- a_hi, out, 8, upper address.
- a_oe, out, 1, upper address output enable.
- ad_out, out, 8, AD bus drive value.
- ad_oe, out, 1, AD bus output enable.
- ad_in, in, 8, AD bus sampled value.
- t_state, out, 3, debug state code: 0 IDLE, 1 T1, 2 T2, 3 TW, 4 T3, 5 T4+, 6 HOLD.
- wait_to, out, 1, sticky WAIT_LIMIT timeout flag.

Behaviour:
- Phase and timing:
  - Internal phase bit ph toggles every x1 edge; reset value 0.
  - One T-state is two x1 cycles: ph=0 is the phi1 half, ph=1 the phi2 half.
  - All state transitions occur only on edges where ph=1, i.e. at the end of a T-state.
- Reset (async, any time including mid-cycle):
  - state IDLE, ph 0, latched cyc/addr/wdata 0, rdata 0.
  - ack 0, done 0, hlda 0, ale 0, rd_n/wr_n/inta_n 1, a_oe/ad_oe 0, io_m/s1/s0 0, wait_to 0.
- Accept point: the end of IDLE, the end of the last T-state of a cycle, or the end of HOLD with hold=0.
  - hold=1 → HOLD. Hold has priority over req.
  - Else req=1 and cyc legal → T1. Latch cyc, addr and wdata; ack pulses on that edge.
  - Else → IDLE.
  - Illegal cyc is never acknowledged; the sequencer stays IDLE.
- Sequence:
  - T1 → T2.
  - From T2 or TW: ready=0 → TW, otherwise → T3.
  - If WAIT_LIMIT>0 and the TW count reaches WAIT_LIMIT → T3 regardless of ready, and set wait_to.
  - T3 → accept point for non-fetch cycles. For fetch: T3 → T4 … up to FETCH_T → accept point.
- Status lines (io_m, s1, s0), valid from T1 through the end of the cycle:
  - fetch 0,1,1
  - mem rd 0,1,0
  - mem wr 0,0,1
  - io rd 1,1,0
  - io wr 1,0,1
  - int ack 1,1,1
  - IDLE and HOLD: 0,0,0.
- ale = 1 only in T1 with ph=0.
- a_oe = 1 in T1…last T-state. a_hi = latched addr[15:8].
- ad_oe and ad_out:
  - T1: ad_oe 1, ad_out = addr[7:0].
  - Writes, T2/TW/T3: ad_oe 1, ad_out = wdata.
  - Otherwise: ad_oe 0.
- Strobes, low in T2, TW and T3:
  - rd_n for fetch/rd types.
  - wr_n for wr types.
  - inta_n for int ack (rd_n stays high).
  - All strobes high in T4+.
- rdata: captures ad_in on the ph=1 edge ending T3, for fetch, rd and int-ack cycles only.
- done: pulses on the edge ending the cycle's last T-state (T3, or T4/T6 for fetch).
- HOLD state:
  - hlda = 1; all output enables 0, strobes 1.
  - Leave HOLD at the end of a T-state once hold=0; hlda drops on that same edge.
  - hold asserted mid-cycle is ignored until the accept point.
- Back-to-back cycles: req held high gives T1 immediately after the last T-state, with no IDLE in between.

Test Plan:
- Reset: resetn_in=0 for 56 x1 cycles, then release → all outputs at reset values; t_state=0; ph starts at 0.
- Mem read, addr=0x2050, ad_in=0xA5, ready=1 → ack pulse; ale high for 1 x1 cycle; ad_out=0x50 in T1; rd_n low 4 x1 cycles; rdata=0xA5; done 6 x1 cycles after T1 entry; status 0,1,0.
- IO write, wdata=0x3C, ready low for 2 T-states → exactly 2 TW; wr_n low 8 x1 cycles; ad_out=0x3C in T2–T3; status 1,0,1.
- Fetch with FETCH_T=4 then FETCH_T=6 → 8 and 12 x1 cycles T1-to-done; strobes high in T4+; back-to-back fetch has no IDLE between cycles.
- hold=1 mid-read → cycle completes normally, then HOLD with hlda=1 and ad_oe=a_oe=0; release hold → hlda=0 at the end of the T-state; pending req accepted next.
- WAIT_LIMIT=3, ready stuck 0 → 3 TW then T3; wait_to=1 and sticky until reset; resetn_in pulse during TW → immediate reset values; cyc=110 with req=1 → no ack, stays IDLE.
